calculator_core: RTL and testbench

- Multi-cycle integer arithmetic unit directly upstream of the 8-digit seven-segment display stage.
- Latches two 16-bit operands and an opcode on a start-button rising edge, then computes add, sub, mul or div.
- Mul uses 16-step shift-add; div uses 16-step restoring division.
- Presents a 32-bit result held stable until the next completion, plus busy/done/err status for the display and control logic.

---
 rtl/calculator_core.sv | 150 +++++++++++++++
 tb/tb_calculator_core.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calculator_core.sv
// calculator_core: multi-cycle unsigned add/sub/mul/div unit feeding the
// seven-segment display stage. Mul is 16-step shift-add, div is 16-step
// restoring division; result is held until the next completion.
module calculator_core #(
    parameter int OP_W   = 2,
    parameter int DATA_W = 16,
    parameter int ITER   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  start,
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   cal_result,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int CNT_W = $clog2(ITER);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(2);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    logic [1:0]            state;
    logic                  start_q;
    logic [CNT_W-1:0]      cnt;
    logic [OP_W-1:0]       op_r;
    logic [DATA_W-1:0]     a_r;
    logic [DATA_W-1:0]     b_r;
    logic [2*DATA_W-1:0]   acc;
    logic [2*DATA_W-1:0]   result_r;
    logic                  err_r;

    logic [DATA_W:0]       sum;
    logic [DATA_W:0]       diff;
    logic [2*DATA_W-1:0]   mul_next;
    logic [DATA_W:0]       rem_sh;
    logic [DATA_W:0]       rem_sub;
    logic                  rem_ge;
    logic [DATA_W:0]       rem_next;
    logic [DATA_W-1:0]     quo_next;
    logic                  last_iter;
    logic                  div_zero;

    // Datapath: single-step add/sub and one mul/div iteration per cycle.
    // For div, acc[DATA_W:0] holds the partial remainder and a_r shifts
    // the dividend out at the top while quotient bits enter at the bottom.
    always_comb begin
        sum       = {1'b0, a_r} + {1'b0, b_r};
        diff      = {1'b0, a_r} - {1'b0, b_r};
        mul_next  = acc + (b_r[cnt] ? ({{DATA_W{1'b0}}, a_r} << cnt) : '0);
        rem_sh    = {acc[DATA_W-1:0], a_r[DATA_W-1]};
        rem_sub   = rem_sh - {1'b0, b_r};
        rem_ge    = (rem_sh >= {1'b0, b_r});
        rem_next  = rem_ge ? rem_sub : rem_sh;
        quo_next  = {a_r[DATA_W-2:0], rem_ge};
        last_iter = (cnt == LAST_CNT);
        div_zero  = (b_r == '0);
    end

    // Control FSM, operand latching, iteration and result/err registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            start_q  <= 1'b0;
            cnt      <= '0;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
        end else begin
            start_q <= start;
            if (!locked) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !start_q) begin
                            state <= S_RUN;
                            a_r   <= a;
                            b_r   <= b;
                            op_r  <= op;
                            cnt   <= '0;
                            acc   <= '0;
                        end
                    end
                    S_RUN: begin
                        case (op_r)
                            OP_ADD: begin
                                result_r <= {{(DATA_W-1){1'b0}}, sum};
                                err_r    <= 1'b0;
                                state    <= S_DONE;
                            end
                            OP_SUB: begin
                                result_r <= {{(DATA_W-1){diff[DATA_W]}}, diff};
                                err_r    <= 1'b0;
                                state    <= S_DONE;
                            end
                            OP_MUL: begin
                                acc <= mul_next;
                                cnt <= cnt + 1'b1;
                                if (last_iter) begin
                                    result_r <= mul_next;
                                    err_r    <= 1'b0;
                                    state    <= S_DONE;
                                end
                            end
                            default: begin
                                if (div_zero) begin
                                    result_r <= '1;
                                    err_r    <= 1'b1;
                                    state    <= S_DONE;
                                end else begin
                                    acc[DATA_W:0] <= rem_next;
                                    a_r           <= quo_next;
                                    cnt           <= cnt + 1'b1;
                                    if (last_iter) begin
                                        result_r <= {rem_next[DATA_W-1:0], quo_next};
                                        err_r    <= 1'b0;
                                        state    <= S_DONE;
                                    end
                                end
                            end
                        endcase
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);
    assign cal_result = result_r;
    assign err        = err_r;

endmodule

// File: tb/tb_calculator_core.sv
// Scoreboard bench for calculator_core: stimulus pushes expected results
// from an arithmetic reference model, a negedge monitor pops on done.
module tb_calculator_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        locked;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] cal_result;
    logic        busy;
    logic        done;
    logic        err;

    calculator_core #(.OP_W(2), .DATA_W(16), .ITER(16)) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .start(start), .op(op),
        .a(a), .b(b), .cal_result(cal_result), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        e;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: plain arithmetic on the unsigned operands.
    function automatic exp_t model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t r;
        r.e   = 1'b0;
        r.lat = 1;
        case (o)
            2'd0: r.res = 32'(x) + 32'(y);
            2'd1: r.res = 32'(x) - 32'(y);
            2'd2: begin r.res = 32'(x) * 32'(y); r.lat = 16; end
            default: begin
                if (y == 16'd0) begin
                    r.res = 32'hFFFF_FFFF;
                    r.e   = 1'b1;
                end else begin
                    r.res = {x % y, x / y};
                    r.lat = 16;
                end
            end
        endcase
        return r;
    endfunction

    // Monitor: compares on done, checks busy length and result/err holding.
    logic [31:0] mon_last = '0;
    logic        mon_err  = 1'b0;
    int          busy_n   = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_last = '0;
            mon_err  = 1'b0;
            busy_n   = 0;
        end else begin
            if (busy) busy_n++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", cal_result, e.res);
                    check("err", 32'(err), 32'(e.e));
                    check("busy_cycles", 32'(busy_n), 32'(e.lat));
                    check("busy_in_done", 32'(busy), 32'd0);
                end
                mon_last = cal_result;
                mon_err  = err;
                busy_n   = 0;
            end else begin
                check("result_hold", cal_result, mon_last);
                check("err_hold", 32'(err), 32'(mon_err));
                if (!busy) busy_n = 0;
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input bit repulse);
        int k;
        @(negedge clk);
        a = x; b = y; op = o; start = 1'b1;
        last_exp = model(o, x, y);
        sb.push_back(last_exp);
        @(posedge clk);
        #1;
        a = 16'($urandom); b = 16'($urandom); op = 2'($urandom);
        @(negedge clk);
        start = 1'b0;
        if (repulse) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (k >= 40) begin
            n_bad++;
            $display("FAIL done_timeout: got no done within %0d cycles required one", k);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;
        rst_n = 1'b0; locked = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        last_exp.res = '0; last_exp.e = 1'b0; last_exp.lat = 0;
        #2;
        check("reset_result", cal_result, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_op(2'd0, 16'hFFFF, 16'h0001, 1'b0);
        do_op(2'd1, 16'h0003, 16'h0005, 1'b0);
        do_op(2'd2, 16'h1234, 16'h5678, 1'b1);
        do_op(2'd3, 16'h0064, 16'h0007, 1'b1);
        do_op(2'd3, 16'h0064, 16'h0000, 1'b0);
        do_op(2'd0, 16'h0001, 16'h0002, 1'b0);
        do_op(2'd2, 16'hFFFF, 16'hFFFF, 1'b0);
        do_op(2'd3, 16'hFFFF, 16'h0001, 1'b0);
        do_op(2'd1, 16'h0000, 16'hFFFF, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            do_op(ro, ra, rb, (ro[1] && rb != 16'd0) ? bit'($urandom_range(0, 1)) : 1'b0);
        end

        // Abort a mul by dropping locked, then return locked with start held.
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; op = 2'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hold", cal_result, last_exp.res);
        start = 1'b1;
        repeat (2) @(negedge clk);
        locked = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_retrigger", 32'(busy), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a div.
        do_op(2'd2, 16'h00FF, 16'h0101, 1'b0);
        @(negedge clk);
        a = 16'h0064; b = 16'h0007; op = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("areset_result", cal_result, 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_done", 32'(done), 32'd0);
        check("areset_err", 32'(err), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        last_exp.res = '0;

        do_op(2'd0, 16'h8000, 16'h8000, 1'b0);
        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
